// File: rtl/pwm_bank_if.sv
// Duty-write bus from the SPI register file into the PWM bank.
interface pwm_bank_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [CNT_W-1:0] wr_duty;

    modport master (output wr_en, wr_sel, wr_duty);
    modport slave  (input  wr_en, wr_sel, wr_duty);
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared prescaler and period counter, double-buffered
// per-channel duty registers that swap at the period boundary.
module pwm_bank #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_bank_if.slave             wr,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_start
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      duty_pend [NUM_CH];
    logic [CNT_W-1:0]      duty_act  [NUM_CH];
    logic                  tick_c;
    logic                  boundary_c;
    logic [NUM_CH-1:0]     wr_hit_c;

    // Prescaler compare is live, so lowering prescale below pre_cnt ticks immediately.
    always_comb begin
        tick_c     = (pre_cnt >= prescale);
        boundary_c = tick_c && (cnt == CNT_MAX);
    end

    // Write decode; selects at or above NUM_CH match no channel and are dropped.
    always_comb begin
        wr_hit_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = wr.wr_en && (wr.wr_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            if (tick_c) begin
                pre_cnt <= '0;
                cnt     <= cnt + CNT_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end
            period_start <= boundary_c;
        end
    end

    // A write landing on the boundary bypasses the pending register into the active one.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                duty_pend[i] <= '0;
                duty_act[i]  <= '0;
                pwm_out[i]   <= 1'b0;
            end else begin
                if (wr_hit_c[i]) begin
                    duty_pend[i] <= wr.wr_duty;
                end
                if (boundary_c) begin
                    duty_act[i] <= wr_hit_c[i] ? wr.wr_duty : duty_pend[i];
                end
                pwm_out[i] <= ch_en[i] && (cnt < duty_act[i]);
            end
        end
    end
endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: per-cycle reference model feeding a scoreboard queue,
// a duty table checked over full periods, and hand sequences for shadowing, prescale and reset.
module tb_pwm_bank;
    localparam int unsigned NUM_CH     = 6;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned PRESCALE_W = 4;
    localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          PERIOD     = 1 << CNT_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_CH-1:0]     ch_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [NUM_CH-1:0]     pwm_out;
    logic                  period_start;

    pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) wr_if ();

    pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr_if),
        .ch_en        (ch_en),
        .prescale     (prescale),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int duty;
        int exp_high;
    } duty_vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int m_pre;
    int m_cnt;
    int m_pend [NUM_CH];
    int m_act  [NUM_CH];
    int m_high [NUM_CH];
    int m_len;

    logic [NUM_CH:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Advance the model one clock with the currently driven inputs, then compare the DUT.
    task automatic step();
        logic [NUM_CH-1:0] e_pwm;
        logic              e_ps;
        logic [NUM_CH:0]   e;
        bit                tick;
        bit                bnd;
        e_pwm = '0;
        e_ps  = 1'b0;
        if (rst) begin
            m_pre = 0;
            m_cnt = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
        end else begin
            tick = (m_pre >= int'(prescale));
            bnd  = tick && (m_cnt == PERIOD - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                e_pwm[i] = ch_en[i] && (m_cnt < m_act[i]);
            end
            e_ps = bnd;
            if (wr_if.wr_en && int'(wr_if.wr_sel) < NUM_CH) begin
                m_pend[int'(wr_if.wr_sel)] = int'(wr_if.wr_duty);
            end
            if (bnd) begin
                for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
            end
            if (tick) begin
                m_pre = 0;
                m_cnt = (m_cnt + 1) % PERIOD;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        exp_q.push_back({e_ps, e_pwm});
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb", 32'({period_start, pwm_out}), 32'(e));
        end
    endtask

    task automatic write(input int sel, input int duty);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_sel  = SEL_W'(sel);
        wr_if.wr_duty = CNT_W'(duty);
        step();
        wr_if.wr_en   = 1'b0;
    endtask

    task automatic wait_ps(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            step();
            if (period_start) break;
        end
        check(name, 32'(period_start), 32'd1);
    endtask

    // Runs from just after a period_start up to and including the next one,
    // optionally injecting one write at iteration wr_at.
    task automatic measure(input string name, input int wr_at, input int wsel, input int wduty,
                           input int budget);
        m_len = 0;
        for (int i = 0; i < NUM_CH; i++) m_high[i] = 0;
        for (int k = 0; k < budget; k++) begin
            if (k == wr_at) begin
                wr_if.wr_en   = 1'b1;
                wr_if.wr_sel  = SEL_W'(wsel);
                wr_if.wr_duty = CNT_W'(wduty);
            end
            step();
            wr_if.wr_en = 1'b0;
            m_len++;
            for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) m_high[i]++;
            if (period_start) break;
        end
        check(name, 32'(period_start), 32'd1);
    endtask

    duty_vec_t vecs [8];

    initial begin
        vecs[0] = '{sel: 0, duty: 64,  exp_high: 64};
        vecs[1] = '{sel: 1, duty: 0,   exp_high: 0};
        vecs[2] = '{sel: 2, duty: 255, exp_high: 255};
        vecs[3] = '{sel: 3, duty: 1,   exp_high: 1};
        vecs[4] = '{sel: 4, duty: 128, exp_high: 128};
        vecs[5] = '{sel: 5, duty: 200, exp_high: 200};
        vecs[6] = '{sel: 6, duty: 99,  exp_high: -1};
        vecs[7] = '{sel: 7, duty: 33,  exp_high: -1};

        rst           = 1'b1;
        ch_en         = '1;
        prescale      = '0;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_sel  = '0;
        wr_if.wr_duty = CNT_W'(77);
        m_pre = 0;
        m_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end

        // Reset with a write pending: nothing may be captured.
        step();
        step();
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        rst         = 1'b0;
        wr_if.wr_en = 1'b0;
        wait_ps("first_ps", 300);
        measure("reset_period", -1, 0, 0, 300);
        check("reset_duty_ch0", 32'(m_high[0]), 32'd0);
        check("period_len", 32'(m_len), 32'(PERIOD));

        // Duty table, including writes to out-of-range selects.
        for (int v = 0; v < 8; v++) write(vecs[v].sel, vecs[v].duty);
        wait_ps("table_ps", 300);
        measure("table_period", -1, 0, 0, 300);
        check("table_len", 32'(m_len), 32'(PERIOD));
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_high >= 0) begin
                check("table_high", 32'(m_high[vecs[v].sel]), 32'(vecs[v].exp_high));
            end
        end

        // Shadowing: mid-period write waits, boundary-cycle write takes effect at once.
        write(0, 50);
        wait_ps("shadow_ps", 300);
        measure("shadow_p0", 100, 0, 200, 300);
        check("shadow_mid", 32'(m_high[0]), 32'd50);
        measure("shadow_p1", PERIOD - 1, 0, 10, 300);
        check("shadow_next", 32'(m_high[0]), 32'd200);
        measure("shadow_p2", -1, 0, 0, 300);
        check("boundary_write", 32'(m_high[0]), 32'd10);
        measure("shadow_p3", -1, 0, 0, 300);
        check("boundary_pend", 32'(m_high[0]), 32'd10);

        // Live channel enable.
        repeat (20) step();
        ch_en[2] = 1'b0;
        step();
        check("ch_en_off", 32'(pwm_out[2]), 32'd0);
        ch_en = '1;

        // Prescaler: period stretches by prescale+1, then an early lowering.
        prescale = PRESCALE_W'(3);
        wait_ps("pre3_ps", 2000);
        measure("pre3_period", -1, 0, 0, 2000);
        check("pre3_len", 32'(m_len), 32'(4 * PERIOD));
        check("pre3_high0", 32'(m_high[0]), 32'd40);
        check("pre3_high4", 32'(m_high[4]), 32'd512);
        for (int k = 0; k < 8 && m_pre != 2; k++) step();
        check("pre_at_2", 32'(m_pre), 32'd2);
        prescale = '0;
        step();
        wait_ps("pre0_ps", 2000);
        measure("pre0_period", -1, 0, 0, 300);
        check("pre0_len", 32'(m_len), 32'(PERIOD));

        // Reset mid-period with outputs high.
        for (int k = 0; k < 300 && m_cnt != 100; k++) step();
        check("pre_reset_high", 32'(pwm_out[5]), 32'd1);
        rst = 1'b1;
        step();
        check("reset_mid", 32'(pwm_out), 32'd0);
        rst = 1'b0;
        wait_ps("post_reset_ps", 300);
        measure("post_reset_period", -1, 0, 0, 300);
        for (int i = 0; i < NUM_CH; i++) check("post_reset_low", 32'(m_high[i]), 32'd0);
        write(5, 200);
        wait_ps("rewrite_ps", 300);
        measure("rewrite_period", -1, 0, 0, 300);
        check("rewrite_high", 32'(m_high[5]), 32'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
